// File: rtl/req_ack_sender_fifo.sv
// FIFO-buffered REQ/ACK sender: words queue in clk1 and cross one at a time using a 2-phase or 4-phase handshake.
// Optional macro REQ_ACK_SYNC_EN inserts a 2-flop synchronizer on ack.
module req_ack_sender_fifo #(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 4,
  parameter int FOUR_PHASE = 0
) (
  input  logic                     clk1,
  input  logic                     rst1_n,
  input  logic                     valid,
  output logic                     ready,
  input  logic [DWIDTH-1:0]        din,
  output logic                     req,
  input  logic                     ack,
  output logic [DWIDTH-1:0]        dout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                ack_s;
  logic                push;
  logic                launch;
  logic                req_next;

`ifdef REQ_ACK_SYNC_EN
  logic ack_meta;
  logic ack_sync;

  // ack may come straight from clk2, so resolve it through two clk1 flops
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_sync <= ack_meta;
    end
  end

  assign ack_s = ack_sync;
`else
  assign ack_s = ack;
`endif

  assign ready = (count != CW'(DEPTH));
  assign push  = valid & ready;
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    req_next   = req;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          launch     = 1'b1;
          state_next = (FOUR_PHASE != 0) ? ST_WAIT_HI : ST_WAIT;
        end
      end
      // 2-phase completion chains straight into the next launch when words remain
      ST_WAIT: begin
        if (ack_s == req) begin
          if (count != '0) begin
            launch = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_HI: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!ack_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (launch) begin
      req_next = (FOUR_PHASE != 0) ? 1'b1 : ~req;
    end
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state  <= ST_IDLE;
      req    <= 1'b0;
      dout   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      req   <= req_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; emptiness is tracked by count and pointers
  always_ff @(posedge clk1) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule
